// File: rtl/sd_pkg.sv
// Shared constants and types for the SD block-read arbiter.
package sd_pkg;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StArb  = 3'd1;
  localparam logic [2:0] StCmd  = 3'd2;
  localparam logic [2:0] StResp = 3'd3;
  localparam logic [2:0] StData = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  typedef enum logic [1:0] {
    ErrOk    = 2'd0,
    ErrR1    = 2'd1,
    ErrRetry = 2'd2,
    ErrRange = 2'd3
  } done_err_e;

  localparam logic [5:0]  Cmd17Index = 6'd17;
  localparam int unsigned BlockBytes = 512;

  // SDSC cards take a byte address, SDHC/SDXC a block number.
  function automatic logic [31:0] lba_to_arg(input logic [31:0] lba, input logic sdhc);
    return sdhc ? lba : {lba[22:0], 9'd0};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after the pointer, pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdW = $clog2(NumReq)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  output logic [NumReq-1:0] grant_o,
  output logic [IdW-1:0]    grant_id_o,
  output logic              any_o
);

  logic [IdW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned idx;
    idx        = 0;
    grant_o    = '0;
    grant_id_o = '0;
    any_o      = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = (32'(ptr_q) + i) % NumReq;
      if (!any_o && req_i[idx]) begin
        any_o        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_id_o   = IdW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_o) begin
      ptr_d = (grant_id_o == IdW'(NumReq - 1)) ? '0 : grant_id_o + IdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sd_read_arbiter.sv
// Shares the SPI-mode SD command/data engine between NUM_REQ block readers, one CMD17
// per grant, with retry on response/token timeout or CRC failure.
module sd_read_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TOKEN_TIMEOUT = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*32-1:0]      req_lba,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       card_ready,
  input  logic                       card_sdhc,
  output logic                       eng_cmd_valid,
  input  logic                       eng_cmd_ready,
  output logic [5:0]                 eng_cmd_index,
  output logic [31:0]                eng_cmd_arg,
  input  logic                       eng_resp_valid,
  input  logic [7:0]                 eng_resp_r1,
  input  logic                       eng_resp_timeout,
  input  logic                       eng_data_valid,
  input  logic [7:0]                 eng_data,
  input  logic                       eng_data_last,
  input  logic                       eng_data_crc_ok,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic [1:0]                 done_err
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
  localparam int unsigned TmoW   = $clog2(TOKEN_TIMEOUT + 1);

  logic [2:0]        state_q, state_d;
  logic [IdW-1:0]    id_q, id_d;
  logic [31:0]       arg_q, arg_d;
  logic [1:0]        err_q, err_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [9:0]        cnt_q, cnt_d;

  logic              out_valid_q, out_last_q;
  logic [7:0]        out_data_q;
  logic [IdW-1:0]    out_id_q;

  logic [NUM_REQ-1:0] grant;
  logic [IdW-1:0]     grant_id;
  logic               grant_any;
  logic               advance;
  logic               retry_evt;
  logic [31:0]        lba_sel;

  rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_rr (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req_valid),
    .advance_i  (advance),
    .grant_o    (grant),
    .grant_id_o (grant_id),
    .any_o      (grant_any)
  );

  assign lba_sel = req_lba[{grant_id, 5'd0} +: 32];

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    arg_d     = arg_q;
    err_d     = err_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    advance   = 1'b0;
    retry_evt = 1'b0;

    case (state_q)
      StIdle: begin
        if (card_ready && |req_valid) state_d = StArb;
      end
      StArb: begin
        if (grant_any) begin
          advance = 1'b1;
          id_d    = grant_id;
          if (!card_sdhc && (lba_sel[31:23] != '0)) begin
            err_d   = ErrRange;
            state_d = StDone;
          end else begin
            arg_d   = lba_to_arg(lba_sel, card_sdhc);
            err_d   = ErrOk;
            state_d = StCmd;
          end
        end else begin
          // Every requester withdrew between IDLE and ARB.
          state_d = StIdle;
        end
      end
      StCmd: begin
        cnt_d = '0;
        if (eng_cmd_ready) state_d = StResp;
      end
      StResp: begin
        if (eng_resp_valid) begin
          if (eng_resp_timeout) begin
            retry_evt = 1'b1;
          end else if (eng_resp_r1 != 8'h00) begin
            err_d   = ErrR1;
            state_d = StDone;
          end else begin
            tmo_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (eng_data_valid) begin
          cnt_d = cnt_q + 10'd1;
          if (eng_data_last) begin
            if ((cnt_q == 10'(BlockBytes - 1)) && eng_data_crc_ok) begin
              err_d   = ErrOk;
              state_d = StDone;
            end else begin
              retry_evt = 1'b1;
            end
          end
        end else if (cnt_q == '0) begin
          // Waiting for the start token: the budget only covers the gap to the first byte.
          if (tmo_q >= TmoW'(TOKEN_TIMEOUT - 1)) retry_evt = 1'b1;
          else tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: begin
        retry_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (retry_evt) begin
      if (retry_q < RetryW'(MAX_RETRY)) begin
        retry_d = retry_q + RetryW'(1);
        state_d = StCmd;
      end else begin
        err_d   = ErrRetry;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      id_q    <= '0;
      arg_q   <= '0;
      err_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      arg_q   <= arg_d;
      err_q   <= err_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // One registered stage on the byte stream: fixed 1-clk latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= (state_q == StData) && eng_data_valid;
      out_data_q  <= eng_data;
      out_id_q    <= id_q;
      out_last_q  <= (state_q == StData) && eng_data_valid &&
                     (cnt_q == 10'(BlockBytes - 1));
    end
  end

  assign req_ready     = (state_q == StArb) ? grant : '0;
  assign eng_cmd_valid = (state_q == StCmd);
  assign eng_cmd_index = eng_cmd_valid ? Cmd17Index : '0;
  assign eng_cmd_arg   = arg_q;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

  assign done_valid = (state_q == StDone);
  assign done_id    = done_valid ? id_q : '0;
  assign done_err   = done_valid ? err_q : '0;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Self-checking bench for sd_read_arbiter: table of single-request scenarios plus
// round-robin and mid-transfer reset sequences, with a byte scoreboard.
module tb_sd_read_arbiter;

  localparam int unsigned NumReq = 4;
  localparam int unsigned TokTmo = 64;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NumReq-1:0]   req_valid;
  logic [NumReq*32-1:0] req_lba;
  logic [NumReq-1:0]   req_ready;
  logic                card_ready, card_sdhc;
  logic                eng_cmd_valid, eng_cmd_ready;
  logic [5:0]          eng_cmd_index;
  logic [31:0]         eng_cmd_arg;
  logic                eng_resp_valid, eng_resp_timeout;
  logic [7:0]          eng_resp_r1;
  logic                eng_data_valid, eng_data_last, eng_data_crc_ok;
  logic [7:0]          eng_data;
  logic                out_valid, out_last;
  logic [7:0]          out_data;
  logic [1:0]          out_id;
  logic                done_valid;
  logic [1:0]          done_id, done_err;

  sd_read_arbiter #(
    .NUM_REQ       (NumReq),
    .MAX_RETRY     (3),
    .TOKEN_TIMEOUT (TokTmo)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_lba          (req_lba),
    .req_ready        (req_ready),
    .card_ready       (card_ready),
    .card_sdhc        (card_sdhc),
    .eng_cmd_valid    (eng_cmd_valid),
    .eng_cmd_ready    (eng_cmd_ready),
    .eng_cmd_index    (eng_cmd_index),
    .eng_cmd_arg      (eng_cmd_arg),
    .eng_resp_valid   (eng_resp_valid),
    .eng_resp_r1      (eng_resp_r1),
    .eng_resp_timeout (eng_resp_timeout),
    .eng_data_valid   (eng_data_valid),
    .eng_data         (eng_data),
    .eng_data_last    (eng_data_last),
    .eng_data_crc_ok  (eng_data_crc_ok),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_id           (out_id),
    .out_last         (out_last),
    .done_valid       (done_valid),
    .done_id          (done_id),
    .done_err         (done_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] id;
    logic       last;
  } out_exp_t;

  typedef struct {
    logic [1:0] id;
    logic [1:0] err;
  } done_t;

  typedef struct {
    int          rq;
    logic        sdhc;
    logic [31:0] lba;
    logic [31:0] arg;
    int          n_tmo;   // leading attempts answered with a response timeout
    logic [7:0]  r1;
    int          n_tok;   // then attempts with R1 ok but no data token
    int          n_crc;   // then attempts whose block fails CRC
    int          cmds;
    logic [1:0]  err;
  } vec_t;

  out_exp_t exp_q[$];
  done_t    done_seen[$];
  int       n_checks = 0;
  int       n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({req_ready, eng_cmd_valid, eng_cmd_index, eng_cmd_arg, out_valid,
                     out_data, out_id, out_last, done_valid, done_id, done_err}), 64'd0);
  endtask

  // Byte scoreboard and completion capture.
  always @(negedge clk) begin
    out_exp_t e;
    done_t    d;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_unexpected", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_byte", 64'({out_id, out_last, out_data}), 64'({e.id, e.last, e.data}));
      end
    end
    if (rst_n && done_valid) begin
      d.id  = done_id;
      d.err = done_err;
      done_seen.push_back(d);
    end
  end

  task automatic send_bytes(input int n, input int rq, input bit crc_ok, input bit with_last);
    out_exp_t e;
    for (int b = 0; b < n; b++) begin
      while ($urandom_range(0, 3) == 0) begin
        eng_data_valid = 1'b0;
        tick();
      end
      eng_data_valid  = 1'b1;
      eng_data        = 8'($urandom);
      eng_data_last   = with_last && (b == n - 1);
      eng_data_crc_ok = crc_ok && with_last && (b == n - 1);
      e.data = eng_data;
      e.id   = 2'(rq);
      e.last = (b == 511);
      exp_q.push_back(e);
      tick();
    end
    eng_data_valid  = 1'b0;
    eng_data_last   = 1'b0;
    eng_data_crc_ok = 1'b0;
  endtask

  task automatic req_grant(input int rq, input logic [31:0] lba, output bit ok);
    req_lba[32*rq +: 32] = lba;
    req_valid[rq]        = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
    check("grant", 64'(req_ready), 64'(4'b0001 << rq));
    tick();
    req_valid[rq] = 1'b0;
  endtask

  // Plays the engine for one granted request until its completion pulse.
  task automatic serve(input vec_t v);
    int    attempt;
    int    cmds;
    bit    finished;
    bit    got;
    done_t d;
    attempt  = 0;
    cmds     = 0;
    finished = 1'b0;
    for (int w = 0; w < 12 && !finished; w++) begin
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (done_seen.size() != 0 || eng_cmd_valid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("serve_wait", 64'd0, 64'd1);
        return;
      end
      if (done_seen.size() != 0) begin
        d = done_seen.pop_front();
        check("done_id", 64'(d.id), 64'(v.rq));
        check("done_err", 64'(d.err), 64'(v.err));
        check("cmd_count", 64'(cmds), 64'(v.cmds));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        finished = 1'b1;
      end else begin
        cmds++;
        check("cmd_arg", 64'({eng_cmd_index, eng_cmd_arg}), 64'({6'd17, v.arg}));
        eng_cmd_ready = 1'b1;
        tick();
        eng_cmd_ready = 1'b0;
        tick();
        eng_resp_valid   = 1'b1;
        eng_resp_timeout = (attempt < v.n_tmo);
        eng_resp_r1      = (attempt < v.n_tmo) ? 8'hFF : v.r1;
        tick();
        eng_resp_valid   = 1'b0;
        eng_resp_timeout = 1'b0;
        eng_resp_r1      = 8'h00;
        if (attempt >= v.n_tmo + v.n_tok && v.r1 == 8'h00) begin
          tick();
          tick();
          send_bytes(512, v.rq, attempt >= v.n_tmo + v.n_tok + v.n_crc, 1'b1);
        end
        attempt++;
      end
    end
    if (!finished) check("serve_done", 64'd0, 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    bit    ok;
    int    k;
    int    extra;
    done_t d;
    logic [NumReq-1:0] rr_exp;
    vec_t  v;

    vecs[0] = '{0, 1'b1, 32'h0000_0010, 32'h0000_0010, 0, 8'h00, 0, 0, 1, 2'd0};
    vecs[1] = '{1, 1'b0, 32'h0000_0003, 32'h0000_0600, 0, 8'h00, 0, 0, 1, 2'd0};
    vecs[2] = '{2, 1'b0, 32'h0080_0000, 32'h0000_0000, 0, 8'h00, 0, 0, 0, 2'd3};
    vecs[3] = '{3, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2, 8'h00, 0, 0, 3, 2'd0};
    vecs[4] = '{0, 1'b1, 32'h0000_0005, 32'h0000_0005, 4, 8'h00, 0, 0, 4, 2'd2};
    vecs[5] = '{1, 1'b1, 32'h0000_0007, 32'h0000_0007, 0, 8'h04, 0, 0, 1, 2'd1};
    vecs[6] = '{2, 1'b0, 32'h007F_FFFF, 32'hFFFF_FE00, 0, 8'h00, 0, 1, 2, 2'd0};
    vecs[7] = '{3, 1'b1, 32'h0000_0020, 32'h0000_0020, 0, 8'h00, 1, 0, 2, 2'd0};
    vecs[8] = '{1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 8'h00, 0, 0, 0, 2'd3};
    vecs[9] = '{0, 1'b1, 32'h0000_0001, 32'h0000_0001, 1, 8'h00, 1, 1, 4, 2'd0};

    rst_n = 1'b0;
    req_valid = '0;
    req_lba = '0;
    card_ready = 1'b1;
    card_sdhc = 1'b1;
    eng_cmd_ready = 1'b0;
    eng_resp_valid = 1'b0;
    eng_resp_r1 = 8'h00;
    eng_resp_timeout = 1'b0;
    eng_data_valid = 1'b0;
    eng_data = 8'h00;
    eng_data_last = 1'b0;
    eng_data_crc_ok = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    // Round robin with all four held: range errors keep each grant short.
    card_sdhc = 1'b0;
    for (int i = 0; i < NumReq; i++) req_lba[32*i +: 32] = 32'h0080_0000;
    req_valid = 4'b1111;
    k = 0;
    for (int c = 0; c < 100 && k < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        rr_exp = 4'b0001 << (k % 4);
        check("rr_grant", 64'(req_ready), 64'(rr_exp));
        k++;
      end
    end
    check("rr_grant_count", 64'(k), 64'd5);
    tick();
    req_valid = '0;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready != '0) extra++;
    end
    check("rr_no_extra_grant", 64'(extra), 64'd0);
    check("rr_done_count", 64'(done_seen.size()), 64'd5);
    for (int i = 0; i < 5 && done_seen.size() != 0; i++) begin
      d = done_seen.pop_front();
      check("rr_done", 64'({d.id, d.err}), 64'({2'(i % 4), 2'd3}));
    end
    tick();

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      card_sdhc = v.sdhc;
      req_grant(v.rq, v.lba, ok);
      if (ok) serve(v);
      tick();
    end

    // Reset while requester 2 is a hundred bytes into its block.
    card_sdhc = 1'b1;
    req_grant(2, 32'h0000_0040, ok);
    k = 0;
    for (int c = 0; c < 50 && !eng_cmd_valid; c++) begin
      @(negedge clk);
      k++;
    end
    check("rst_seq_cmd", 64'({eng_cmd_valid, eng_cmd_arg}), 64'({1'b1, 32'h0000_0040}));
    eng_cmd_ready = 1'b1;
    tick();
    eng_cmd_ready = 1'b0;
    tick();
    eng_resp_valid = 1'b1;
    tick();
    eng_resp_valid = 1'b0;
    tick();
    send_bytes(100, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_data");
    exp_q.delete();
    done_seen.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Pointer must be back at 0, so requester 0 beats requester 3.
    req_lba[0 +: 32]  = 32'h0000_0099;
    req_lba[96 +: 32] = 32'h0000_0033;
    req_valid = 4'b1001;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    check("post_reset_grant", 64'(req_ready), 64'(4'b0001));
    tick();
    req_valid = '0;
    v = '{0, 1'b1, 32'h0000_0099, 32'h0000_0099, 0, 8'h00, 0, 0, 1, 2'd0};
    serve(v);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
